// File: rtl/gates_arbiter.sv
// rtl/gates_arbiter.sv - round-robin arbiter sharing one combinational gates block between two requesters
module gates_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] g_a,
  output logic [WIDTH-1:0] g_b,
  input  logic [WIDTH-1:0] g_y1,
  input  logic [WIDTH-1:0] g_y2,
  input  logic [WIDTH-1:0] g_y3,
  input  logic [WIDTH-1:0] g_y4,
  input  logic [WIDTH-1:0] g_y5,
  output logic             busy,
  output logic [7:0]       ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] g_a_q, g_a_d;
  logic [WIDTH-1:0] g_b_q, g_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       ops_done_q, ops_done_d;

  logic gnt_id;
  logic accept;
  logic rsp_ready_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      op_q       <= 3'd0;
      g_a_q      <= '0;
      g_b_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ops_done_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      op_q       <= op_d;
      g_a_q      <= g_a_d;
      g_b_q      <= g_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ops_done_q <= ops_done_d;
    end
  end

  always_comb begin
    // On a tie the requester not served last wins; a lone valid always wins.
    gnt_id        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept        = (state_q == IDLE) && (req0_valid || req1_valid);
    rsp_ready_sel = id_q ? rsp1_ready : rsp0_ready;

    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    op_d       = op_q;
    g_a_d      = g_a_q;
    g_b_d      = g_b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ops_done_d = ops_done_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          g_a_d   = gnt_id ? req1_a  : req0_a;
          g_b_d   = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_err_d = 1'b0;
        case (op_q)
          3'd0:    rsp_data_d = g_y1;
          3'd1:    rsp_data_d = g_y2;
          3'd2:    rsp_data_d = g_y3;
          3'd3:    rsp_data_d = g_y4;
          3'd4:    rsp_data_d = g_y5;
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          state_d    = IDLE;
          ops_done_d = ops_done_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  gnt_id;
  assign rsp0_valid = (state_q == RESP) && !id_q;
  assign rsp1_valid = (state_q == RESP) &&  id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign g_a        = g_a_q;
  assign g_b        = g_b_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_gates_arbiter.sv
// tb/tb_gates_arbiter.sv - directed bench for gates_arbiter with a behavioural gates block
module tb_gates_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [3:0] g_a, g_b, g_y1, g_y2, g_y3, g_y4, g_y5;
  logic       busy;
  logic [7:0] ops_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared gates instance.
  assign g_y1 = g_a & g_b;
  assign g_y2 = g_a | g_b;
  assign g_y3 = g_a ^ g_b;
  assign g_y4 = ~(g_a & g_b);
  assign g_y5 = ~(g_a | g_b);

  gates_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .g_a(g_a), .g_b(g_b), .g_y1(g_y1), .g_y2(g_y2), .g_y3(g_y3), .g_y4(g_y4), .g_y5(g_y5),
    .busy(busy), .ops_done(ops_done)
  );

  // Runs one operation to completion with response ready held high; reports what was seen.
  task automatic issue(input bit k, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       output logic [3:0] data, output logic err, output bit rdy_first,
                       output bit lat_ok, output bit tmo);
    int n;
    @(negedge clk);
    if (k) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    rdy_first = k ? req1_ready : req0_ready;
    n = 0;
    while (!(k ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    tmo = (n >= 20);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat_ok = busy && !rsp0_valid && !rsp1_valid;
    @(negedge clk); #1;
    lat_ok = lat_ok && (k ? (rsp1_valid && !rsp0_valid) : (rsp0_valid && !rsp1_valid));
    data = rsp_data;
    err  = rsp_err;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, rsp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, rsp0_valid, rsp1_valid, rsp_err});
    end
    checks++;
    if ({g_a, g_b, rsp_data, ops_done} !== 20'h0) begin
      errors++; $display("FAIL reset_regs: got %h expected 00000", {g_a, g_b, rsp_data, ops_done});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] d; logic e; bit r, l, t;
    issue(1'b0, 4'b0101, 4'b0011, 3'd0, d, e, r, l, t);
    checks++;
    if (r !== 1'b1 || t !== 1'b0) begin
      errors++; $display("FAIL basic_ready: got ready=%b timeout=%b expected 1 0", r, t);
    end
    checks++;
    if (l !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", l); end
    checks++;
    if (d !== 4'b0001 || e !== 1'b0) begin
      errors++; $display("FAIL basic_and: got %b err=%b expected 0001 err=0", d, e);
    end
    checks++;
    if (ops_done !== 8'd1) begin errors++; $display("FAIL basic_ops_done: got %0d expected 1", ops_done); end
  endtask

  task automatic test_ops();
    logic [3:0] exp_tbl [4] = '{4'b0111, 4'b0110, 4'b1110, 4'b1000};
    logic [3:0] d; logic e; bit r, l, t;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'b0101, 4'b0011, 3'(i + 1), d, e, r, l, t);
      checks++;
      if (d !== exp_tbl[i] || e !== 1'b0 || l !== 1'b1 || t !== 1'b0) begin
        errors++; $display("FAIL ops_op%0d: got %b err=%b lat=%b to=%b expected %b err=0 lat=1 to=0", i + 1, d, e, l, t, exp_tbl[i]);
      end
      checks++;
      if (g_a !== 4'b0101 || g_b !== 4'b0011) begin
        errors++; $display("FAIL ops_operands%0d: got %b %b expected 0101 0011", i + 1, g_a, g_b);
      end
    end
    checks++;
    if (ops_done !== 8'd5) begin errors++; $display("FAIL ops_count: got %0d expected 5", ops_done); end
  endtask

  task automatic test_illegal();
    logic [3:0] d; logic e; bit r, l, t;
    issue(1'b1, 4'b0101, 4'b0011, 3'd6, d, e, r, l, t);
    checks++;
    if (d !== 4'b0000 || e !== 1'b1 || l !== 1'b1 || t !== 1'b0) begin
      errors++; $display("FAIL illegal_op: got %b err=%b lat=%b to=%b expected 0000 err=1 lat=1 to=0", d, e, l, t);
    end
    issue(1'b1, 4'b0101, 4'b0011, 3'd3, d, e, r, l, t);
    checks++;
    if (d !== 4'b1110 || e !== 1'b0) begin
      errors++; $display("FAIL illegal_recover: got %b err=%b expected 1110 err=0", d, e);
    end
  endtask

  task automatic test_round_robin();
    int n; bit g; bit clean;
    @(negedge clk);
    req0_valid = 1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 3'd2;
    req1_valid = 1; req1_a = 4'b1111; req1_b = 4'b0001; req1_op = 3'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
      g = req1_ready;
      checks++;
      if (g !== 1'(i % 2) || (req0_ready && req1_ready) || n >= 20) begin
        errors++; $display("FAIL rr_grant%0d: got %b (r0=%b r1=%b) expected %0d", i, g, req0_ready, req1_ready, i % 2);
      end
      @(negedge clk); #1;
      clean = busy && !req0_ready && !req1_ready && !rsp0_valid && !rsp1_valid;
      @(negedge clk); #1;
      clean = clean && !req0_ready && !req1_ready;
      checks++;
      if (!clean || rsp0_valid !== !g || rsp1_valid !== g || rsp_data !== (g ? 4'b0001 : 4'b0110)) begin
        errors++; $display("FAIL rr_resp%0d: got v0=%b v1=%b data=%b clean=%b expected v0=%b v1=%b data=%b clean=1",
                           i, rsp0_valid, rsp1_valid, rsp_data, clean, !g, g, g ? 4'b0001 : 4'b0110);
      end
      @(negedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (ops_done !== 8'd11) begin errors++; $display("FAIL rr_count: got %0d expected 11", ops_done); end
  endtask

  task automatic test_backpressure();
    int n; bit stable;
    @(negedge clk);
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 4'b1010; req0_b = 4'b0110; req0_op = 3'd4;
    req1_valid = 1; req1_op = 3'd1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 20 || req1_ready) begin errors++; $display("FAIL bp_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      stable = stable && rsp0_valid && !rsp1_valid && busy && !req1_ready && rsp_data == 4'b0001 && !rsp_err;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable: got 0 expected 1 (data=%b v0=%b)", rsp_data, rsp0_valid); end
    rsp0_ready = 1;
    @(negedge clk);
    req1_valid = 0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 8'd12) begin
      errors++; $display("FAIL bp_complete: got v0=%b busy=%b ops=%0d expected 0 0 12", rsp0_valid, busy, ops_done);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    logic [3:0] d; logic e; bit r, l, t;
    @(negedge clk);
    req0_valid = 1; req0_a = 4'b1111; req0_b = 4'b1111; req0_op = 3'd0;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req0_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_exec: got busy=%b expected 1", busy); end
    reset_n = 0;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, rsp_err, g_a, g_b, rsp_data, ops_done} !== 24'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 000000",
                         {busy, rsp0_valid, rsp1_valid, rsp_err, g_a, g_b, rsp_data, ops_done});
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_resp: got v0=%b busy=%b expected 0 0", rsp0_valid, busy);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_first_tie: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 255; i++) issue(1'b0, 4'b0011, 4'b0101, 3'd0, d, e, r, l, t);
    checks++;
    if (ops_done !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", ops_done); end
    issue(1'b0, 4'b0011, 4'b0101, 3'd0, d, e, r, l, t);
    checks++;
    if (ops_done !== 8'd0 || d !== 4'b0001) begin
      errors++; $display("FAIL wrap_0: got ops=%0d data=%b expected 0 0001", ops_done, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_illegal();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gates_arbiter.md
Name: gates_arbiter

Overview:
- Shares one instance of the team's 4-bit bitwise gates block (y1=AND, y2=OR, y3=XOR, y4=NAND, y5=NOR) between two requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Drives the gates operands from registers and returns the selected gate output on a valid/ready response channel.
- Sits between requester logic and the gates instance, which stays purely combinational.

Parameters:
- WIDTH, 4, operand and result width; must match the gates instance.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req0_op  in  3  requester 0 gate select: 0=y1 AND, 1=y2 OR, 2=y3 XOR, 3=y4 NAND, 4=y5 NOR, 5..7 illegal
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp0_valid  out  1  result available for requester 0
- rsp0_ready  in  1  requester 0 takes the result
- rsp1_valid  out  1  result available for requester 1
- rsp1_ready  in  1  requester 1 takes the result
- rsp_data  out  WIDTH  result, shared by both response channels
- rsp_err  out  1  illegal op flag, qualified by rspN_valid
- g_a  out  WIDTH  to gates a
- g_b  out  WIDTH  to gates b
- g_y1..g_y5  in  WIDTH each  from gates y1..y5
- busy  out  1  high whenever state is not IDLE
- ops_done  out  8  count of completed responses

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; g_a, g_b, rsp_data, ops_done = 0.
  - rsp_err, rsp0_valid, rsp1_valid, busy = 0.
  - last_served=1, so requester 0 wins the first tie.
  - Reset mid-operation drops any in-flight operation and its response; no partial response is ever produced.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: only one valid, grant it; both valid, grant the one that is not last_served.
  - reqK_ready=1 only for the granted K while in IDLE; both ready signals are 0 in every other state.
  - On the edge where the granted valid and its ready are both 1 (accept):
    - g_a<=reqK_a, g_b<=reqK_b, op and id latched.
    - last_served<=K.
    - state<=EXEC.
- EXEC (exactly 1 cycle):
  - On the next edge, rsp_data<=selected g_yN.
  - For op 5..7: rsp_data<=0 and rsp_err<=1; otherwise rsp_err<=0.
  - state<=RESP.
- RESP:
  - rsp[id]_valid=1; the other response valid=0.
  - rsp_data and rsp_err are held stable until handshake.
  - On the edge with rsp[id]_ready=1: state<=IDLE, ops_done<=ops_done+1 (8-bit wrap 255->0).
  - rsp[id]_ready may be held high in advance; the handshake completes on the first RESP cycle.
- Latency: accept at edge E0, rsp valid after edge E1 (2 edges). Minimum issue interval is 3 cycles.
- g_a and g_b hold the last operands after completion and change only on accept.
- A requester dropping valid before accept has no effect and is not recorded.
- Request inputs are ignored outside IDLE, including new valids arriving while the other requester is in RESP.
- The response of one requester is never returned on the other's channel.

Test Plan:
- Reset then req0 only, a=0101 b=0011 op=0 -> req0_ready=1 in IDLE; 2 edges later rsp0_valid=1, rsp_data=0001, rsp_err=0; ops_done=1 after handshake.
- Same operands on req0 with op=1,2,3,4 in sequence -> rsp_data 0111, 0110, 1110, 1000 respectively; g_a=0101, g_b=0011 throughout.
- req0 and req1 both held valid for 4 operations -> grant order 0,1,0,1; the response appears only on the matching rspN_valid; no more than 1 operation in flight.
- req1 op=6 -> rsp1_valid=1, rsp_data=0000, rsp_err=1; the next legal op returns rsp_err=0.
- Back-pressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp_data stable, busy=1, req1_ready=0 throughout; completes on the first ready cycle.
- Assert reset_n=0 during EXEC -> all outputs 0 immediately, no response issued; after release, req0 wins the first tie; 256 completions wrap ops_done to 0.
